mem_bus_arbiter: RTL and testbench

Arbitrates the single processor-to-memory bus between the icache controller and the dcache controller. It forwards one command per cycle and returns the memory's acceptance tag only to the requester that was granted. It records which requester owns each outstanding load tag and routes later data returns (mem2proc_tag) to that owner. It sits between the two cache controllers and the memory model, at the top of the memory hierarchy.

---
 rtl/mem_bus_arbiter_pkg.sv | 26 ++
 rtl/mem_tag_table.sv | 47 ++++
 rtl/mem_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the processor-to-memory bus arbiter.
//   BUS_COMMAND : command encoding seen on every bus segment
//   ARB_OWNER   : which cache controller owns a grant or an outstanding tag
//   TAG_ENTRY   : one slot of the outstanding-load ownership table
package mem_bus_arbiter_pkg;

  localparam int NUM_MEM_TAGS = 16;
  localparam int DATA_SIZE    = 64;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_I = 1'b1
  } ARB_OWNER;

  typedef struct packed {
    logic     valid;
    ARB_OWNER owner;
  } TAG_ENTRY;

endpackage

// File: rtl/mem_tag_table.sv
// Ownership table for outstanding memory load tags.
//   clock, reset  : clock and synchronous active-high reset
//   alloc_en      : write {1, alloc_owner} at alloc_idx on the next edge
//   lookup_en     : a tag is returning this cycle at lookup_idx
//   lookup_entry  : current (pre-edge) contents of lookup_idx, 0 when idle
// A returning tag clears its slot on the edge; an allocation to the same
// slot in the same cycle takes precedence, so the new owner survives.
module mem_tag_table
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = NUM_MEM_TAGS
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        alloc_en,
  input  logic [$clog2(NUM_TAGS)-1:0] alloc_idx,
  input  ARB_OWNER                    alloc_owner,
  input  logic                        lookup_en,
  input  logic [$clog2(NUM_TAGS)-1:0] lookup_idx,
  output TAG_ENTRY                    lookup_entry
);

  localparam int TAG_W = $clog2(NUM_TAGS);

  TAG_ENTRY tag_mem [NUM_TAGS];

  assign lookup_entry = lookup_en ? tag_mem[lookup_idx] : '0;

  // NOTE: the valid bits must be reset, otherwise a stale entry after reset
  // would misroute a return instead of flagging it as spurious.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        tag_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (alloc_en && alloc_idx == TAG_W'(i)) begin
          tag_mem[i] <= '{valid: 1'b1, owner: alloc_owner};
        end else if (lookup_en && lookup_idx == TAG_W'(i)) begin
          tag_mem[i].valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter for the single processor-to-memory bus shared by the icache and
// dcache controllers.
//   clock, reset        : clock and synchronous active-high reset
//   d2arb_* / i2arb_*   : dcache / icache requests (command, address, data)
//   mem2proc_response   : acceptance tag from memory, 0 = rejected
//   mem2proc_tag/data   : returning load tag and data, tag 0 = none
//   proc2mem_*          : command forwarded from the granted requester
//   arb2d_* / arb2i_*   : per-requester acceptance tag, return tag and data
//   spurious_tag        : a nonzero returning tag has no recorded owner
// All bus paths are combinational; only grant history, starvation count and
// tag ownership are registered.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_TAGS     = NUM_MEM_TAGS,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  BUS_COMMAND                  d2arb_command,
  input  logic [31:0]                 d2arb_addr,
  input  logic [DATA_SIZE-1:0]        d2arb_data,
  input  BUS_COMMAND                  i2arb_command,
  input  logic [31:0]                 i2arb_addr,
  input  logic [$clog2(NUM_TAGS)-1:0] mem2proc_response,
  input  logic [DATA_SIZE-1:0]        mem2proc_data,
  input  logic [$clog2(NUM_TAGS)-1:0] mem2proc_tag,
  output BUS_COMMAND                  proc2mem_command,
  output logic [31:0]                 proc2mem_addr,
  output logic [DATA_SIZE-1:0]        proc2mem_data,
  output logic [$clog2(NUM_TAGS)-1:0] arb2d_response,
  output logic [$clog2(NUM_TAGS)-1:0] arb2i_response,
  output logic [$clog2(NUM_TAGS)-1:0] arb2d_tag,
  output logic [$clog2(NUM_TAGS)-1:0] arb2i_tag,
  output logic [DATA_SIZE-1:0]        arb2d_data,
  output logic [DATA_SIZE-1:0]        arb2i_data,
  output logic                        spurious_tag
);

  localparam int TAG_W = $clog2(NUM_TAGS);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic             sticky_valid;
  ARB_OWNER         sticky_owner;
  logic [CNT_W-1:0] starve_cnt;

  logic     d_req, i_req, sticky_req;
  logic     grant_valid, accepted;
  ARB_OWNER grant_owner;
  logic     lookup_en;
  TAG_ENTRY lookup_entry;

  // Requests are masked during reset so every bus output falls to idle.
  assign d_req      = !reset && (d2arb_command != BUS_NONE);
  assign i_req      = !reset && (i2arb_command != BUS_NONE);
  assign sticky_req = (sticky_owner == OWN_D) ? d_req : i_req;

  assign grant_valid = d_req || i_req;
  assign accepted    = grant_valid && (mem2proc_response != '0);

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_owner = OWN_D;
    if (sticky_valid && sticky_req) begin
      grant_owner = sticky_owner;
    end else if (starve_cnt == CNT_W'(STARVE_LIMIT) && i_req) begin
      grant_owner = OWN_I;
    end else if (d_req) begin
      grant_owner = OWN_D;
    end else begin
      grant_owner = OWN_I;
    end
  end

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (grant_valid) begin
      if (grant_owner == OWN_D) begin
        proc2mem_command = d2arb_command;
        proc2mem_addr    = d2arb_addr;
        proc2mem_data    = d2arb_data;
      end else begin
        proc2mem_command = i2arb_command;
        proc2mem_addr    = i2arb_addr;
      end
    end
  end

  assign arb2d_response = (grant_valid && grant_owner == OWN_D) ? mem2proc_response : '0;
  assign arb2i_response = (grant_valid && grant_owner == OWN_I) ? mem2proc_response : '0;

  // Return routing reads the entry as it stood before this edge, so a
  // same-cycle reallocation of the tag does not steal the return.
  assign lookup_en    = !reset && (mem2proc_tag != '0);
  assign arb2d_tag    = (lookup_entry.valid && lookup_entry.owner == OWN_D) ? mem2proc_tag : '0;
  assign arb2i_tag    = (lookup_entry.valid && lookup_entry.owner == OWN_I) ? mem2proc_tag : '0;
  assign spurious_tag = lookup_en && !lookup_entry.valid;

  assign arb2d_data = mem2proc_data;
  assign arb2i_data = mem2proc_data;

  mem_tag_table #(
    .NUM_TAGS (NUM_TAGS)
  ) u_tag_table (
    .clock        (clock),
    .reset        (reset),
    .alloc_en     (accepted && proc2mem_command == BUS_LOAD),
    .alloc_idx    (mem2proc_response),
    .alloc_owner  (grant_owner),
    .lookup_en    (lookup_en),
    .lookup_idx   (mem2proc_tag),
    .lookup_entry (lookup_entry)
  );

  // Sticky grant pins a rejected requester to the bus so its address stays
  // stable across retries; the starvation counter bounds icache waiting.
  // NOTE: state registers use non-blocking assignments so every update in
  // this block sees the pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      sticky_valid <= 1'b0;
      sticky_owner <= OWN_D;
      starve_cnt   <= '0;
    end else begin
      sticky_valid <= grant_valid && !accepted;
      if (grant_valid) begin
        sticky_owner <= grant_owner;
      end
      if (!i_req) begin
        starve_cnt <= '0;
      end else if (!(grant_valid && grant_owner == OWN_I)) begin
        if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
          starve_cnt <= starve_cnt + CNT_W'(1);
        end
      end else if (accepted) begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// randomized traffic, all compared against a rule-level reference model.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int NT    = NUM_MEM_TAGS;
  localparam int TW    = $clog2(NT);
  localparam int LIMIT = 4;

  logic              clock;
  logic              reset;
  BUS_COMMAND        d2arb_command, i2arb_command, proc2mem_command;
  logic [31:0]       d2arb_addr, i2arb_addr, proc2mem_addr;
  logic [DATA_SIZE-1:0] d2arb_data, mem2proc_data, proc2mem_data;
  logic [DATA_SIZE-1:0] arb2d_data, arb2i_data;
  logic [TW-1:0]     mem2proc_response, mem2proc_tag;
  logic [TW-1:0]     arb2d_response, arb2i_response, arb2d_tag, arb2i_tag;
  logic              spurious_tag;

  int checks = 0;
  int errors = 0;

  // Reference model: owner per tag (-1 none, 0 dcache, 1 icache),
  // the requester left waiting on a rejection, and the icache loss streak.
  int owner_of [NT];
  int m_sticky_v, m_sticky_own, m_starve, m_grant;

  mem_bus_arbiter #(
    .NUM_TAGS     (NT),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .d2arb_command     (d2arb_command),
    .d2arb_addr        (d2arb_addr),
    .d2arb_data        (d2arb_data),
    .i2arb_command     (i2arb_command),
    .i2arb_addr        (i2arb_addr),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .arb2d_response    (arb2d_response),
    .arb2i_response    (arb2i_response),
    .arb2d_tag         (arb2d_tag),
    .arb2i_tag         (arb2i_tag),
    .arb2d_data        (arb2d_data),
    .arb2i_data        (arb2i_data),
    .spurious_tag      (spurious_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input BUS_COMMAND dc, input logic [31:0] da,
                       input logic [63:0] dd, input BUS_COMMAND ic, input logic [31:0] ia,
                       input logic [TW-1:0] rsp, input logic [TW-1:0] rt);
    reset             = rst;
    d2arb_command     = dc;
    d2arb_addr        = da;
    d2arb_data        = dd;
    i2arb_command     = ic;
    i2arb_addr        = ia;
    mem2proc_response = rsp;
    mem2proc_tag      = rt;
    mem2proc_data     = {$urandom, $urandom};
    #2;
  endtask

  task automatic model_check();
    bit dr, ir;
    int g;
    logic [1:0] ec;
    logic [31:0] ea;
    logic [63:0] ed;
    logic [TW-1:0] edr, eir, etd, eti;
    bit esp;
    dr = !reset && d2arb_command != BUS_NONE;
    ir = !reset && i2arb_command != BUS_NONE;
    if (!dr && !ir)                                           g = -1;
    else if (m_sticky_v && (m_sticky_own == 0 ? dr : ir))     g = m_sticky_own;
    else if (m_starve == LIMIT && ir)                         g = 1;
    else if (dr)                                              g = 0;
    else                                                      g = 1;
    ec = 2'(BUS_NONE); ea = '0; ed = '0;
    if (g == 0) begin
      ec = 2'(d2arb_command); ea = d2arb_addr; ed = d2arb_data;
    end else if (g == 1) begin
      ec = 2'(i2arb_command); ea = i2arb_addr;
    end
    edr = (g == 0) ? mem2proc_response : '0;
    eir = (g == 1) ? mem2proc_response : '0;
    etd = '0; eti = '0; esp = 1'b0;
    if (!reset && mem2proc_tag != 0) begin
      if (owner_of[mem2proc_tag] == 0)      etd = mem2proc_tag;
      else if (owner_of[mem2proc_tag] == 1) eti = mem2proc_tag;
      else                                  esp = 1'b1;
    end
    check("cmd",    64'(proc2mem_command), 64'(ec));
    check("addr",   64'(proc2mem_addr), 64'(ea));
    check("data",   proc2mem_data, ed);
    check("d_resp", 64'(arb2d_response), 64'(edr));
    check("i_resp", 64'(arb2i_response), 64'(eir));
    check("d_tag",  64'(arb2d_tag), 64'(etd));
    check("i_tag",  64'(arb2i_tag), 64'(eti));
    check("spur",   64'(spurious_tag), 64'(esp));
    check("d_data", arb2d_data, mem2proc_data);
    check("i_data", arb2i_data, mem2proc_data);
    m_grant = g;
  endtask

  // Advance one clock and apply the spec's state rules to the model.
  task automatic tick();
    bit ir;
    BUS_COMMAND gc;
    @(posedge clock);
    ir = !reset && i2arb_command != BUS_NONE;
    gc = (m_grant == 0) ? d2arb_command : i2arb_command;
    if (reset) begin
      for (int i = 0; i < NT; i++) owner_of[i] = -1;
      m_sticky_v = 0; m_starve = 0;
    end else begin
      if (mem2proc_tag != 0) owner_of[mem2proc_tag] = -1;
      if (m_grant >= 0 && mem2proc_response != 0 && gc == BUS_LOAD)
        owner_of[mem2proc_response] = m_grant;
      m_sticky_v = (m_grant >= 0 && mem2proc_response == 0);
      if (m_grant >= 0) m_sticky_own = m_grant;
      if (!ir)                          m_starve = 0;
      else if (m_grant != 1)            m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else if (mem2proc_response != 0)  m_starve = 0;
    end
    #1;
  endtask

  task automatic step(input logic rst, input BUS_COMMAND dc, input logic [31:0] da,
                      input logic [63:0] dd, input BUS_COMMAND ic, input logic [31:0] ia,
                      input logic [TW-1:0] rsp, input logic [TW-1:0] rt);
    drive(rst, dc, da, dd, ic, ia, rsp, rt);
    model_check();
    tick();
  endtask

  initial begin
    for (int i = 0; i < NT; i++) owner_of[i] = -1;
    m_sticky_v = 0; m_sticky_own = 0; m_starve = 0; m_grant = -1;
    drive(1'b1, BUS_NONE, '0, '0, BUS_NONE, '0, '0, '0);
    @(posedge clock);
    #1;

    // Reset with live requests and a return: bus stays idle.
    drive(1'b1, BUS_LOAD, 32'h1000, 64'h11, BUS_LOAD, 32'h2000, 4'd3, 4'd3);
    check("rst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
    check("rst_spur", 64'(spurious_tag), 64'd0);
    model_check(); tick();
    step(1'b1, BUS_NONE, '0, '0, BUS_NONE, '0, '0, '0);

    // Lone dcache load, then its return.
    drive(1'b0, BUS_LOAD, 32'h1000, 64'h0, BUS_NONE, '0, 4'd3, 4'd0);
    check("t1_addr", 64'(proc2mem_addr), 64'h1000);
    check("t1_dresp", 64'(arb2d_response), 64'd3);
    check("t1_iresp", 64'(arb2i_response), 64'd0);
    model_check(); tick();
    drive(1'b0, BUS_NONE, '0, '0, BUS_NONE, '0, 4'd0, 4'd3);
    check("t1_dtag", 64'(arb2d_tag), 64'd3);
    check("t1_itag", 64'(arb2i_tag), 64'd0);
    model_check(); tick();
    drive(1'b0, BUS_NONE, '0, '0, BUS_NONE, '0, 4'd0, 4'd3);
    check("t1_cleared", 64'(spurious_tag), 64'd1);
    model_check(); tick();

    // Both request: dcache wins four times, then icache is forced through.
    drive(1'b0, BUS_LOAD, 32'h1100, '0, BUS_LOAD, 32'h2100, 4'd5, 4'd0);
    check("t2_dresp", 64'(arb2d_response), 64'd5);
    check("t2_iresp", 64'(arb2i_response), 64'd0);
    model_check(); tick();
    step(1'b0, BUS_LOAD, 32'h1104, '0, BUS_LOAD, 32'h2100, 4'd6, 4'd0);
    step(1'b0, BUS_LOAD, 32'h1108, '0, BUS_LOAD, 32'h2100, 4'd8, 4'd0);
    step(1'b0, BUS_LOAD, 32'h110c, '0, BUS_LOAD, 32'h2100, 4'd9, 4'd0);
    drive(1'b0, BUS_LOAD, 32'h1110, '0, BUS_LOAD, 32'h2100, 4'd10, 4'd0);
    check("t2_starve_iresp", 64'(arb2i_response), 64'd10);
    check("t2_starve_addr", 64'(proc2mem_addr), 64'h2100);
    model_check(); tick();
    drive(1'b0, BUS_NONE, '0, '0, BUS_NONE, '0, 4'd0, 4'd10);
    check("t2_itag", 64'(arb2i_tag), 64'd10);
    model_check(); tick();

    // Sticky icache across rejections while dcache keeps requesting.
    step(1'b0, BUS_NONE, '0, '0, BUS_LOAD, 32'h2200, 4'd0, 4'd0);
    drive(1'b0, BUS_LOAD, 32'h1200, '0, BUS_LOAD, 32'h2200, 4'd0, 4'd0);
    check("t3_sticky_addr", 64'(proc2mem_addr), 64'h2200);
    model_check(); tick();
    drive(1'b0, BUS_LOAD, 32'h1200, '0, BUS_LOAD, 32'h2200, 4'd7, 4'd0);
    check("t3_iresp", 64'(arb2i_response), 64'd7);
    check("t3_dresp", 64'(arb2d_response), 64'd0);
    model_check(); tick();

    // Store allocates no tag: its "return" is spurious.
    step(1'b0, BUS_STORE, 32'h3000, 64'hdead_beef_0123_4567, BUS_NONE, '0, 4'd2, 4'd0);
    drive(1'b0, BUS_NONE, '0, '0, BUS_NONE, '0, 4'd0, 4'd2);
    check("t4_spur", 64'(spurious_tag), 64'd1);
    check("t4_dtag", 64'(arb2d_tag), 64'd0);
    model_check(); tick();

    // Same-cycle return and reallocation of tag 4, then reset.
    step(1'b0, BUS_LOAD, 32'h4000, '0, BUS_NONE, '0, 4'd4, 4'd0);
    drive(1'b0, BUS_NONE, '0, '0, BUS_LOAD, 32'h5000, 4'd4, 4'd4);
    check("t5_dtag", 64'(arb2d_tag), 64'd4);
    check("t5_iresp", 64'(arb2i_response), 64'd4);
    model_check(); tick();
    drive(1'b0, BUS_NONE, '0, '0, BUS_NONE, '0, 4'd0, 4'd4);
    check("t5_itag", 64'(arb2i_tag), 64'd4);
    model_check(); tick();
    step(1'b0, BUS_LOAD, 32'h4100, '0, BUS_NONE, '0, 4'd4, 4'd0);
    drive(1'b1, BUS_LOAD, 32'h4200, '0, BUS_LOAD, 32'h5100, 4'd6, 4'd5);
    check("t5_rst_tag", 64'(arb2d_tag), 64'd0);
    check("t5_rst_spur", 64'(spurious_tag), 64'd0);
    model_check(); tick();
    step(1'b1, BUS_NONE, '0, '0, BUS_NONE, '0, 4'd0, 4'd0);
    drive(1'b0, BUS_NONE, '0, '0, BUS_NONE, '0, 4'd0, 4'd4);
    check("t5_post_rst", 64'(spurious_tag), 64'd1);
    model_check(); tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic rst;
      BUS_COMMAND dc, ic;
      logic [TW-1:0] rsp, rt;
      rst = ($urandom_range(0, 79) == 0);
      dc  = BUS_COMMAND'(2'($urandom_range(0, 2)));
      ic  = ($urandom_range(0, 1) == 1) ? BUS_LOAD : BUS_NONE;
      rsp = ($urandom_range(0, 3) == 0) ? '0 : TW'($urandom_range(1, NT - 1));
      rt  = ($urandom_range(0, 1) == 0) ? '0 : TW'($urandom_range(1, NT - 1));
      step(rst, dc, $urandom, {$urandom, $urandom}, ic, $urandom, rsp, rt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
